// File: rtl/mac_rx.sv
// mac_rx: GMII receive framer - strips preamble/SFD, filters destination MAC, extracts header,
// streams payload with FCS removed and reports CRC-32 status on the final payload byte.
module mac_rx #(
  parameter logic [47:0] P_LOCAL_MAC = 48'h00_00_00_00_00_00,
  parameter bit          P_CRC_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_local_mac,
  input  logic        i_local_mac_valid,
  input  logic [7:0]  i_GMII_data,
  input  logic        i_GMII_valid,
  output logic [47:0] o_recv_source_mac,
  output logic [15:0] o_recv_type,
  output logic        o_recv_bcast,
  output logic [7:0]  o_recv_data,
  output logic        o_recv_valid,
  output logic        o_recv_last,
  output logic [15:0] o_recv_len,
  output logic        o_crc_ok,
  output logic        o_crc_err,
  output logic        o_frame_err
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP, WAIT_IDLE} state_t;
  state_t          state_q, state_d;
  logic [2:0]      pre_q, pre_d;
  logic [4:0]      n_q, n_d;
  logic [55:0]     hdr_q, hdr_d;
  logic [4:0][7:0] sr_q, sr_d;
  logic [31:0]     crc_q, crc_d;
  logic [47:0]     mac_q, mac_d, fmac_q, fmac_d, src_q, src_d;
  logic [15:0]     type_q, type_d, len_q, len_d;
  logic [7:0]      data_q, data_d;
  logic            bcast_q, bcast_d, valid_q, valid_d, last_q, last_d;
  logic            ok_q, ok_d, err_q, err_d, ferr_q, ferr_d;
  logic [47:0]     dest;
  logic [63:0]     hdr_full;
  logic [15:0]     len_inc;
  logic            fcs_match;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  assign dest      = {hdr_q[39:0], i_GMII_data};
  assign hdr_full  = {hdr_q, i_GMII_data};
  assign len_inc   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  // sr_q[3] is the oldest FCS byte once valid falls; it carries crc[7:0]
  assign fcs_match = ~crc_q == {sr_q[0], sr_q[1], sr_q[2], sr_q[3]};

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    n_d     = n_q;
    hdr_d   = hdr_q;
    sr_d    = sr_q;
    crc_d   = crc_q;
    mac_d   = i_local_mac_valid ? i_local_mac : mac_q;
    fmac_d  = fmac_q;
    src_d   = src_q;
    type_d  = type_q;
    bcast_d = bcast_q;
    data_d  = data_q;
    len_d   = len_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: if (i_GMII_valid) begin
        state_d = (i_GMII_data == 8'h55) ? PREAMBLE : DROP;
        ferr_d  = i_GMII_data != 8'h55;
        pre_d   = 3'd1;
      end
      PREAMBLE: begin
        if (!i_GMII_valid) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else if (i_GMII_data == 8'hD5) begin
          state_d = HEADER;
          n_d     = '0;
          crc_d   = '1;
          len_d   = '0;
          fmac_d  = mac_q;
        end else if (i_GMII_data == 8'h55 && pre_q != 3'd7) begin
          pre_d = pre_q + 3'd1;
        end else begin
          ferr_d  = 1'b1;
          state_d = DROP;
        end
      end
      HEADER, PAYLOAD: begin
        if (i_GMII_valid) begin
          sr_d  = {sr_q[3:0], i_GMII_data};
          hdr_d = {hdr_q[47:0], i_GMII_data};
          n_d   = (n_q == 5'd31) ? n_q : n_q + 5'd1;
          crc_d = (n_q >= 5'd4) ? crc_byte(crc_q, sr_q[3]) : crc_q;
          if (state_q == HEADER && n_q == 5'd5) begin
            if (dest != fmac_q && dest != '1) state_d = DROP;
            else bcast_d = dest == '1;
          end
          if (state_q == HEADER && n_q == 5'd13) begin
            src_d   = hdr_full[63:16];
            type_d  = hdr_full[15:0];
            state_d = PAYLOAD;
          end
          if (n_q >= 5'd19) begin
            valid_d = 1'b1;
            data_d  = sr_q[4];
            len_d   = len_inc;
          end
        end else begin
          state_d = IDLE;
          ferr_d  = n_q < 5'd18;
          if (n_q >= 5'd18) begin
            valid_d = n_q >= 5'd19;
            data_d  = sr_q[4];
            len_d   = (n_q >= 5'd19) ? len_inc : len_q;
            last_d  = 1'b1;
            ok_d    = !P_CRC_CHECK || fcs_match;
            err_d   = P_CRC_CHECK && !fcs_match;
          end
        end
      end
      default: if (!i_GMII_valid) state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= WAIT_IDLE;
      pre_q   <= '0;
      n_q     <= '0;
      hdr_q   <= '0;
      sr_q    <= '0;
      crc_q   <= '1;
      mac_q   <= P_LOCAL_MAC;
      fmac_q  <= P_LOCAL_MAC;
      src_q   <= '0;
      type_q  <= '0;
      bcast_q <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      n_q     <= n_d;
      hdr_q   <= hdr_d;
      sr_q    <= sr_d;
      crc_q   <= crc_d;
      mac_q   <= mac_d;
      fmac_q  <= fmac_d;
      src_q   <= src_d;
      type_q  <= type_d;
      bcast_q <= bcast_d;
      data_q  <= data_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_recv_source_mac = src_q;
  assign o_recv_type       = type_q;
  assign o_recv_bcast      = bcast_q;
  assign o_recv_data       = data_q;
  assign o_recv_valid      = valid_q;
  assign o_recv_last       = last_q;
  assign o_recv_len        = len_q;
  assign o_crc_ok          = ok_q;
  assign o_crc_err         = err_q;
  assign o_frame_err       = ferr_q;
endmodule
